fp_param_loader: RTL and testbench
==================================

Name: fp_param_loader

Overview:
- Successor to the per-parameter wire-in scheme. Replaces it with one consolidated, parametrised write channel from the frontpanel host.
- Assembles multi-word (e.g. 48-bit output-preprocessor) values from 16-bit host words and validates channel and parameter addresses.
- Delivers each committed write to osf/pid/router/opp blocks as a single valid/ready transaction carrying a channel mask.
- Sits between the host endpoints and all parameter-consuming modules, in the clk50_in domain.

Parameters:
- N_CHAN, 8, number of addressable channels (max 255; address 0xFF is broadcast).
- N_PARAM, 16, number of parameter IDs per channel.
- W_WORD, 16, host word width.
- N_WORDS, 3, maximum words per parameter value.
- W_PID, 4, width of parameter ID output; must be >= clog2(N_PARAM).

Ports:
- clk50_in  in  1  system clock
- reset_n_in  in  1  asynchronous active-low reset
- wr_addr_in  in  16  [15:8] channel (0xFF = all channels), [7:0] parameter ID; sampled on commit
- wr_data_in  in  W_WORD  data word
- wr_word_stb_in  in  1  single-cycle pulse: push wr_data_in
- wr_commit_stb_in  in  1  single-cycle pulse: commit assembled value
- wr_abort_stb_in  in  1  single-cycle pulse: discard assembled words
- param_valid_out  out  1  transaction valid
- param_ready_in  in  1  downstream accept
- param_id_out  out  W_PID  parameter ID
- param_val_out  out  W_WORD*N_WORDS  value, zero-extended
- param_chan_mask_out  out  N_CHAN  one-hot channel, or all ones for broadcast
- busy_out  out  1  high in states other than IDLE
- err_out  out  3  sticky: [0] word overflow, [1] empty or bad address, [2] commit while busy
- err_clr_in  in  1  clear err_out
- commit_cnt_out  out  16  count of completed handshakes; wraps

Behaviour:
- Reset: all outputs, assembly register, word count and state are 0; state is IDLE.
- States:
  - IDLE: no words held.
  - COLLECT: 1..N_WORDS words held.
  - OFFER: param_valid_out=1.
- Word push, in IDLE or COLLECT:
  - Data is written to assembly bits [k*W_WORD +: W_WORD], where k = word count; LSW arrives first.
  - Word count increments and state goes to COLLECT.
  - At word count = N_WORDS, a further push is dropped and sets err[0]. The held data and count are unchanged.
- Commit, in IDLE or COLLECT, evaluated after any push in the same cycle; the push is included in the commit:
  - Word count 0 → set err[1], remain IDLE.
  - ID >= N_PARAM, or channel >= N_CHAN and != 0xFF → set err[1], clear assembly, go to IDLE.
  - Otherwise go to OFFER the next cycle. Latency commit→valid is 1 cycle. Outputs are registered and held stable while in OFFER. Unwritten upper words read as 0.
- OFFER:
  - On param_valid_out & param_ready_in, go to IDLE the next cycle. Word count and assembly clear, and commit_cnt_out increments (0xFFFF→0).
  - param_ready_in may be high before valid. An accept may occur in the first OFFER cycle.
  - Word pushes are ignored. A commit sets err[2] and is otherwise ignored. Abort is ignored, because valid never drops before handshake.
- Abort in IDLE or COLLECT: clears assembly and word count, state to IDLE. Abort has priority over a push or commit in the same cycle.
- err_clr_in clears err_out. If an error sets in the same cycle, the set wins for that bit.
- Asserting reset mid-OFFER drops the transaction; param_valid_out goes low asynchronously.

Optional Feature:
- Macro FP_PARAM_SHADOW_EN.
- When defined:
  - Adds rd_chan_in (8), rd_pid_in (W_PID) and rd_val_out (W_WORD*N_WORDS).
  - Each accepted transaction is written to a shadow array [N_CHAN][N_PARAM]; broadcast writes every channel entry.
  - rd_val_out is registered with 1-cycle latency.
  - An out-of-range read returns 0. A read of the entry being written in the same cycle returns the old value.
  - Reset clears the array to 0.
- When undefined: these ports are absent and there is no storage.

Test Plan:
- Push 0x1111, 0x2222, 0x3333 to addr 0x0203, then commit with ready=1 → valid for one cycle, starting 1 cycle after commit. id=3, val=0x333322221111, mask=0x04, commit_cnt=1.
- Push 0xBEEF alone to addr 0xFF05, commit, hold ready=0 for 5 cycles → outputs stable, valid held for 5 cycles. On ready: val=0x00000000BEEF, mask=0xFF; busy_out drops the next cycle.
- 4 pushes with N_WORDS=3 → err=3'b001 and the 4th word is absent from val. err_clr_in → err=0.
- Commit with no words → err[1] set, no valid. Commit to addr 0x0810 (N_CHAN=8, ID 16) → err[1] set, no valid.
- While valid is held with ready=0: push, commit and abort → err[2] set; val unchanged; after accept, exactly 1 transaction.
- Push with abort in the same cycle → state IDLE, word count 0. Reset asserted mid-OFFER → valid=0 immediately; commit_cnt=0.

Source files
------------

// File: rtl/fp_param_loader.sv
// fp_param_loader: assembles multi-word host parameter writes and offers
// each committed value as one valid/ready transaction with a channel mask.
// Ports:
//   clk50_in, reset_n_in        clock, async active-low reset
//   wr_addr_in                  [15:8] chan (0xFF bcast), [7:0] param id
//   wr_data_in, wr_*_stb_in     word push / commit / abort pulses
//   param_*                     downstream valid/ready transaction
//   busy_out, err_out           not-idle flag, sticky errors
//   err_clr_in                  clears err_out
//   commit_cnt_out              handshake counter (wraps)
// Optional: define FP_PARAM_SHADOW_EN for a readable shadow array
//   (rd_chan_in, rd_pid_in, rd_val_out).
module fp_param_loader #(
  parameter int N_CHAN  = 8,
  parameter int N_PARAM = 16,
  parameter int W_WORD  = 16,
  parameter int N_WORDS = 3,
  parameter int W_PID   = 4
) (
  input  logic                      clk50_in,
  input  logic                      reset_n_in,
  input  logic [15:0]               wr_addr_in,
  input  logic [W_WORD-1:0]         wr_data_in,
  input  logic                      wr_word_stb_in,
  input  logic                      wr_commit_stb_in,
  input  logic                      wr_abort_stb_in,
  output logic                      param_valid_out,
  input  logic                      param_ready_in,
  output logic [W_PID-1:0]          param_id_out,
  output logic [W_WORD*N_WORDS-1:0] param_val_out,
  output logic [N_CHAN-1:0]         param_chan_mask_out,
  output logic                      busy_out,
  output logic [2:0]                err_out,
  input  logic                      err_clr_in,
  output logic [15:0]               commit_cnt_out
`ifdef FP_PARAM_SHADOW_EN
  ,
  input  logic [7:0]                rd_chan_in,
  input  logic [W_PID-1:0]          rd_pid_in,
  output logic [W_WORD*N_WORDS-1:0] rd_val_out
`endif
);

  localparam int W_VAL = W_WORD * N_WORDS;
  localparam int CNTW  = $clog2(N_WORDS + 1);
  localparam int PW    = (N_PARAM > 1) ? $clog2(N_PARAM) : 1;
  localparam int CW    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OFFER
  } state_t;

  state_t            state_q;
  logic [W_VAL-1:0]  asm_q;
  logic [CNTW-1:0]   cnt_q;

  logic [7:0]        chan;
  logic [7:0]        pid;
  logic [W_VAL-1:0]  asm_push;
  logic [CNTW-1:0]   cnt_push;
  logic              ovf;
  logic              addr_bad;
  logic              live;
  logic [N_CHAN-1:0] mask_n;
  logic [2:0]        err_set;

  assign chan = wr_addr_in[15:8];
  assign pid  = wr_addr_in[7:0];
  assign live = (state_q != OFFER);
  assign busy_out = (state_q != IDLE);

  // Effect of a push this cycle; a commit in the same cycle sees it.
  always_comb begin
    asm_push = asm_q;
    cnt_push = cnt_q;
    ovf      = 1'b0;
    if (wr_word_stb_in) begin
      if (cnt_q == CNTW'(N_WORDS)) begin
        ovf = 1'b1;
      end else begin
        cnt_push = cnt_q + CNTW'(1);
        for (int k = 0; k < N_WORDS; k++) begin
          if (cnt_q == CNTW'(k))
            asm_push[k*W_WORD +: W_WORD] = wr_data_in;
        end
      end
    end
  end

  always_comb begin
    addr_bad = ({1'b0, pid} >= 9'(N_PARAM)) ||
               (({1'b0, chan} >= 9'(N_CHAN)) && (chan != 8'hFF));
    if (chan == 8'hFF)
      mask_n = '1;
    else
      mask_n = N_CHAN'(1) << chan;
    err_set    = 3'b000;
    err_set[0] = live && !wr_abort_stb_in && ovf;
    err_set[1] = live && !wr_abort_stb_in && wr_commit_stb_in &&
                 ((cnt_push == '0) || addr_bad);
    err_set[2] = !live && wr_commit_stb_in;
  end

  always_ff @(posedge clk50_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q             <= IDLE;
      asm_q               <= '0;
      cnt_q               <= '0;
      param_valid_out     <= 1'b0;
      param_id_out        <= '0;
      param_val_out       <= '0;
      param_chan_mask_out <= '0;
      err_out             <= '0;
      commit_cnt_out      <= '0;
    end else begin
      // A set in the same cycle as a clear wins for that bit.
      err_out <= (err_clr_in ? 3'b000 : err_out) | err_set;
      case (state_q)
        IDLE, COLLECT: begin
          if (wr_abort_stb_in) begin
            asm_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (wr_commit_stb_in) begin
            if (cnt_push == '0) begin
              state_q <= IDLE;
            end else if (addr_bad) begin
              asm_q   <= '0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              asm_q               <= asm_push;
              cnt_q               <= cnt_push;
              state_q             <= OFFER;
              param_valid_out     <= 1'b1;
              param_id_out        <= W_PID'(pid);
              param_val_out       <= asm_push;
              param_chan_mask_out <= mask_n;
            end
          end else begin
            asm_q   <= asm_push;
            cnt_q   <= cnt_push;
            state_q <= (cnt_push != '0) ? COLLECT : IDLE;
          end
        end
        OFFER: begin
          if (param_ready_in) begin
            param_valid_out <= 1'b0;
            state_q         <= IDLE;
            asm_q           <= '0;
            cnt_q           <= '0;
            commit_cnt_out  <= commit_cnt_out + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FP_PARAM_SHADOW_EN
  logic [W_VAL-1:0] shadow_q [N_CHAN][N_PARAM];
  logic             hs;
  logic             rd_ok;

  assign hs    = param_valid_out && param_ready_in;
  assign rd_ok = ({1'b0, rd_chan_in} < 9'(N_CHAN)) &&
                 (32'(rd_pid_in) < N_PARAM);

  always_ff @(posedge clk50_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rd_val_out <= '0;
      for (int c = 0; c < N_CHAN; c++)
        for (int p = 0; p < N_PARAM; p++)
          shadow_q[c][p] <= '0;
    end else begin
      rd_val_out <= rd_ok ?
        shadow_q[rd_chan_in[CW-1:0]][rd_pid_in[PW-1:0]] : '0;
      if (hs) begin
        for (int c = 0; c < N_CHAN; c++)
          if (param_chan_mask_out[c])
            shadow_q[c][param_id_out[PW-1:0]] <= param_val_out;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_param_loader.sv
// tb_fp_param_loader: directed vectors with hand-computed expectations
// for fp_param_loader (default parameters).
module tb_fp_param_loader;

  logic        clk50_in = 1'b0;
  logic        reset_n_in;
  logic [15:0] wr_addr_in;
  logic [15:0] wr_data_in;
  logic        wr_word_stb_in;
  logic        wr_commit_stb_in;
  logic        wr_abort_stb_in;
  logic        param_valid_out;
  logic        param_ready_in;
  logic [3:0]  param_id_out;
  logic [47:0] param_val_out;
  logic [7:0]  param_chan_mask_out;
  logic        busy_out;
  logic [2:0]  err_out;
  logic        err_clr_in;
  logic [15:0] commit_cnt_out;
`ifdef FP_PARAM_SHADOW_EN
  logic [7:0]  rd_chan_in;
  logic [3:0]  rd_pid_in;
  logic [47:0] rd_val_out;
`endif

  int total = 0;
  int bad   = 0;

  fp_param_loader dut (
    .clk50_in            (clk50_in),
    .reset_n_in          (reset_n_in),
    .wr_addr_in          (wr_addr_in),
    .wr_data_in          (wr_data_in),
    .wr_word_stb_in      (wr_word_stb_in),
    .wr_commit_stb_in    (wr_commit_stb_in),
    .wr_abort_stb_in     (wr_abort_stb_in),
    .param_valid_out     (param_valid_out),
    .param_ready_in      (param_ready_in),
    .param_id_out        (param_id_out),
    .param_val_out       (param_val_out),
    .param_chan_mask_out (param_chan_mask_out),
    .busy_out            (busy_out),
    .err_out             (err_out),
    .err_clr_in          (err_clr_in),
    .commit_cnt_out      (commit_cnt_out)
`ifdef FP_PARAM_SHADOW_EN
    ,
    .rd_chan_in          (rd_chan_in),
    .rd_pid_in           (rd_pid_in),
    .rd_val_out          (rd_val_out)
`endif
  );

  always #5 clk50_in = ~clk50_in;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50_in);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_data_in     = d;
    wr_word_stb_in = 1'b1;
    tick();
    wr_word_stb_in = 1'b0;
  endtask

  task automatic commit(input logic [15:0] a);
    wr_addr_in       = a;
    wr_commit_stb_in = 1'b1;
    tick();
    wr_commit_stb_in = 1'b0;
  endtask

  task automatic clr_err();
    err_clr_in = 1'b1;
    tick();
    err_clr_in = 1'b0;
  endtask

  initial begin
    reset_n_in       = 1'b0;
    wr_addr_in       = '0;
    wr_data_in       = '0;
    wr_word_stb_in   = 1'b0;
    wr_commit_stb_in = 1'b0;
    wr_abort_stb_in  = 1'b0;
    param_ready_in   = 1'b0;
    err_clr_in       = 1'b0;
`ifdef FP_PARAM_SHADOW_EN
    rd_chan_in       = '0;
    rd_pid_in        = '0;
`endif
    #12;
    check("rst_valid", 64'(param_valid_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_err", 64'(err_out), 64'd0);
    check("rst_val", 64'(param_val_out), 64'd0);
    check("rst_cnt", 64'(commit_cnt_out), 64'd0);
    reset_n_in = 1'b1;
    tick();

    // three-word value, ready already high
    param_ready_in = 1'b1;
    push(16'h1111);
    push(16'h2222);
    check("t1_busy", 64'(busy_out), 64'd1);
    push(16'h3333);
    commit(16'h0203);
    check("t1_valid", 64'(param_valid_out), 64'd1);
    check("t1_id", 64'(param_id_out), 64'd3);
    check("t1_val", 64'(param_val_out), 64'h333322221111);
    check("t1_mask", 64'(param_chan_mask_out), 64'h04);
    tick();
    check("t1_valid_drop", 64'(param_valid_out), 64'd0);
    check("t1_cnt", 64'(commit_cnt_out), 64'd1);
    check("t1_busy_end", 64'(busy_out), 64'd0);

    // broadcast single word, held 5 cycles
    param_ready_in = 1'b0;
    push(16'hBEEF);
    commit(16'hFF05);
    for (int i = 0; i < 5; i++) begin
      check("t2_valid_hold", 64'(param_valid_out), 64'd1);
      check("t2_val_hold", 64'(param_val_out), 64'hBEEF);
      check("t2_mask", 64'(param_chan_mask_out), 64'hFF);
      check("t2_id", 64'(param_id_out), 64'd5);
      tick();
    end
    param_ready_in = 1'b1;
    check("t2_busy_pre", 64'(busy_out), 64'd1);
    tick();
    check("t2_valid_drop", 64'(param_valid_out), 64'd0);
    check("t2_busy_drop", 64'(busy_out), 64'd0);
    check("t2_cnt", 64'(commit_cnt_out), 64'd2);

    // overflow: fourth word dropped
    push(16'hAAAA);
    push(16'hBBBB);
    push(16'hCCCC);
    check("t3_err_none", 64'(err_out), 64'd0);
    push(16'hDDDD);
    check("t3_err_ovf", 64'(err_out), 64'b001);
    commit(16'h0001);
    check("t3_val", 64'(param_val_out), 64'hCCCCBBBBAAAA);
    check("t3_mask", 64'(param_chan_mask_out), 64'h01);
    tick();
    check("t3_cnt", 64'(commit_cnt_out), 64'd3);
    clr_err();
    check("t3_err_clr", 64'(err_out), 64'd0);

    // empty commit and bad addresses
    commit(16'h0001);
    check("t4_empty_err", 64'(err_out), 64'b010);
    check("t4_empty_valid", 64'(param_valid_out), 64'd0);
    clr_err();
    push(16'h1234);
    commit(16'h0810);
    check("t4_bad_err", 64'(err_out), 64'b010);
    check("t4_bad_valid", 64'(param_valid_out), 64'd0);
    check("t4_bad_busy", 64'(busy_out), 64'd0);
    clr_err();
    push(16'h1234);
    commit(16'h0901);
    check("t4_badch_err", 64'(err_out), 64'b010);
    check("t4_badch_valid", 64'(param_valid_out), 64'd0);
    clr_err();
    // bad address cleared the assembly: next value is fresh
    push(16'h0042);
    commit(16'hFF0F);
    check("t4_fresh_val", 64'(param_val_out), 64'h42);
    check("t4_fresh_id", 64'(param_id_out), 64'd15);
    tick();
    check("t4_cnt", 64'(commit_cnt_out), 64'd4);

    // activity during OFFER is ignored, commit flags err[2]
    param_ready_in = 1'b0;
    push(16'h7777);
    commit(16'h0100);
    check("t5_valid", 64'(param_valid_out), 64'd1);
    push(16'h9999);
    commit(16'h0100);
    wr_abort_stb_in = 1'b1;
    tick();
    wr_abort_stb_in = 1'b0;
    check("t5_err_busy", 64'(err_out), 64'b100);
    check("t5_val_keep", 64'(param_val_out), 64'h7777);
    check("t5_valid_keep", 64'(param_valid_out), 64'd1);
    // clear and set in the same cycle: set wins
    err_clr_in       = 1'b1;
    wr_commit_stb_in = 1'b1;
    tick();
    err_clr_in       = 1'b0;
    wr_commit_stb_in = 1'b0;
    check("t5_clr_vs_set", 64'(err_out), 64'b100);
    param_ready_in = 1'b1;
    tick();
    check("t5_valid_drop", 64'(param_valid_out), 64'd0);
    tick();
    tick();
    check("t5_one_txn", 64'(commit_cnt_out), 64'd5);
    check("t5_no_revalid", 64'(param_valid_out), 64'd0);
    clr_err();
    push(16'h0005);
    commit(16'h0102);
    check("t5_fresh_val", 64'(param_val_out), 64'h5);
    tick();

    // push with abort in the same cycle
    wr_data_in      = 16'hF00D;
    wr_word_stb_in  = 1'b1;
    wr_abort_stb_in = 1'b1;
    tick();
    wr_word_stb_in  = 1'b0;
    wr_abort_stb_in = 1'b0;
    check("t6_abort_busy", 64'(busy_out), 64'd0);
    commit(16'h0001);
    check("t6_abort_empty", 64'(err_out), 64'b010);
    check("t6_abort_valid", 64'(param_valid_out), 64'd0);
    clr_err();

`ifdef FP_PARAM_SHADOW_EN
    rd_chan_in = 8'd2;
    rd_pid_in  = 4'd3;
    tick();
    check("sh_c2p3", 64'(rd_val_out), 64'h333322221111);
    rd_chan_in = 8'd6;
    rd_pid_in  = 4'd5;
    tick();
    check("sh_bcast", 64'(rd_val_out), 64'hBEEF);
    rd_chan_in = 8'd9;
    tick();
    check("sh_oor", 64'(rd_val_out), 64'd0);
`endif

    // reset in the middle of OFFER
    param_ready_in = 1'b0;
    push(16'h0101);
    commit(16'h0300);
    check("t7_valid", 64'(param_valid_out), 64'd1);
    #2;
    reset_n_in = 1'b0;
    #1;
    check("t7_rst_valid", 64'(param_valid_out), 64'd0);
    check("t7_rst_cnt", 64'(commit_cnt_out), 64'd0);
    check("t7_rst_busy", 64'(busy_out), 64'd0);
    #10;
    reset_n_in = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
